// File: rtl/pmod_step_decoder.sv
// Stepper coil-phase decoder: synchronizes and filters one-hot phases,
// tracks signed position, step period and illegal-transition faults.
module pmod_step_decoder #(
    parameter int POS_W    = 16,
    parameter int FILT_CYC = 4,
    parameter int PER_W    = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              phase_in,
    input  logic                    pos_clr,
    input  logic                    err_clr,
    output logic [3:0]              phase,
    output logic signed [POS_W-1:0] pos,
    output logic                    dir_out,
    output logic                    moving,
    output logic                    step_pulse,
    output logic                    err_pulse,
    output logic                    fault,
    output logic [7:0]              err_cnt,
    output logic [PER_W-1:0]        period
);

    typedef enum logic [1:0] {IDLE, RUN, FAULT} st_t;

    localparam logic [3:0] FILT = 4'(FILT_CYC);

    st_t              st_q, st_d;
    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    logic [3:0]       sprev_q, sprev_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       phase_q, phase_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic             err_q, err_d;
    logic             fault_q, fault_d;
    logic [7:0]       ecnt_q, ecnt_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [PER_W-1:0] pcnt_q, pcnt_d;

    logic [3:0] s, fwd, rev;
    logic       acc, onehot, illegal, step_fwd, step_rev;

    always_comb begin
        sync1_d  = phase_in;
        sync2_d  = sync1_q;
        sprev_d  = sync2_q;
        s        = sync2_q;
        fwd      = {phase_q[0], phase_q[3:1]};
        rev      = {phase_q[2:0], phase_q[3]};
        onehot   = (s != 4'b0000) && ((s & (s - 4'b0001)) == 4'b0000);
        illegal  = 1'b0;
        step_fwd = 1'b0;
        step_rev = 1'b0;

        // The filter count restarts whenever the synchronized sample moves.
        if (s != sprev_q)
            cnt_d = 4'd1;
        else if (cnt_q < FILT)
            cnt_d = cnt_q + 4'd1;
        else
            cnt_d = cnt_q;
        acc = (cnt_d == FILT) && (s != phase_q);

        st_d    = st_q;
        phase_d = phase_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        err_d   = 1'b0;
        fault_d = fault_q;
        ecnt_d  = ecnt_q;
        per_d   = per_q;
        pcnt_d  = (pcnt_q == '1) ? pcnt_q : pcnt_q + PER_W'(1);

        if (acc) begin
            phase_d = s;
            unique case (st_q)
                IDLE: begin
                    if (s == 4'b0001) st_d = RUN;
                    else              illegal = 1'b1;
                end
                RUN: begin
                    if (s == fwd)          step_fwd = 1'b1;
                    else if (s == rev)     step_rev = 1'b1;
                    else if (s == 4'b0000) st_d = IDLE;
                    else                   illegal = 1'b1;
                end
                FAULT: begin
                    if (s == 4'b0000) st_d = IDLE;
                    else if (onehot)  st_d = RUN;
                    else              illegal = 1'b1;
                end
                default: st_d = IDLE;
            endcase
        end

        if (illegal) begin
            st_d    = FAULT;
            err_d   = 1'b1;
            fault_d = 1'b1;
            if (ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
        end

        if (step_fwd || step_rev) begin
            step_d = 1'b1;
            dir_d  = step_rev;
            per_d  = pcnt_q;
            pcnt_d = PER_W'(1);
            pos_d  = step_rev ? pos_q - POS_W'(1) : pos_q + POS_W'(1);
        end

        if (st_d == IDLE && st_q != IDLE) pcnt_d = '0;
        if (pos_clr) pos_d = '0;
        if (err_clr) begin
            fault_d = 1'b0;
            ecnt_d  = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= IDLE;
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
            sprev_q <= 4'b0000;
            cnt_q   <= 4'd0;
            phase_q <= 4'b0000;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
            fault_q <= 1'b0;
            ecnt_q  <= 8'd0;
            per_q   <= '0;
            pcnt_q  <= '0;
        end else begin
            st_q    <= st_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sprev_q <= sprev_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            err_q   <= err_d;
            fault_q <= fault_d;
            ecnt_q  <= ecnt_d;
            per_q   <= per_d;
            pcnt_q  <= pcnt_d;
        end
    end

    assign phase      = phase_q;
    assign pos        = pos_q;
    assign dir_out    = dir_q;
    assign moving     = (st_q == RUN);
    assign step_pulse = step_q;
    assign err_pulse  = err_q;
    assign fault      = fault_q;
    assign err_cnt    = ecnt_q;
    assign period     = per_q;

endmodule

// File: tb/tb_pmod_step_decoder.sv
// Directed bench for pmod_step_decoder: vector table plus sequences for
// pos_clr priority, error saturation/clear and mid-run reset.
module tb_pmod_step_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  phase_in = 4'b0000;
    logic        pos_clr = 1'b0;
    logic        err_clr = 1'b0;
    logic [3:0]  phase;
    logic [15:0] pos;
    logic        dir_out, moving, step_pulse, err_pulse, fault;
    logic [7:0]  err_cnt;
    logic [19:0] period;

    int checks = 0;
    int failures = 0;
    int n_step = 0;
    int n_err = 0;
    int b_step, b_err;

    pmod_step_decoder dut (
        .clk(clk), .rst(rst), .phase_in(phase_in), .pos_clr(pos_clr),
        .err_clr(err_clr), .phase(phase), .pos(pos), .dir_out(dir_out),
        .moving(moving), .step_pulse(step_pulse), .err_pulse(err_pulse),
        .fault(fault), .err_cnt(err_cnt), .period(period)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (step_pulse) n_step++;
        if (err_pulse) n_err++;
    end

    typedef struct {
        logic [3:0]  ph;
        int          hold;
        logic        pclr;
        logic [3:0]  e_phase;
        logic [15:0] e_pos;
        logic        e_dir;
        logic        e_mov;
        logic        e_flt;
        logic [7:0]  e_ecnt;
        int          e_steps;
        int          e_errs;
        int          e_per;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        phase_in = 4'b0000;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_phase"}, 32'(phase), 32'h0);
        chk({tag, "_pos"}, 32'(pos), 32'h0);
        chk({tag, "_dir"}, 32'(dir_out), 32'h0);
        chk({tag, "_moving"}, 32'(moving), 32'h0);
        chk({tag, "_step"}, 32'(step_pulse), 32'h0);
        chk({tag, "_errp"}, 32'(err_pulse), 32'h0);
        chk({tag, "_fault"}, 32'(fault), 32'h0);
        chk({tag, "_errcnt"}, 32'(err_cnt), 32'h0);
        chk({tag, "_period"}, 32'(period), 32'h0);
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        phase_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0]  = '{4'b0001, 50, 1'b0, 4'b0001, 16'h0000, 1'b0, 1'b1, 1'b0, 8'd0, 0, 0, -1};
        vt[1]  = '{4'b1000, 50, 1'b0, 4'b1000, 16'h0001, 1'b0, 1'b1, 1'b0, 8'd0, 1, 0, -1};
        vt[2]  = '{4'b0100, 50, 1'b0, 4'b0100, 16'h0002, 1'b0, 1'b1, 1'b0, 8'd0, 2, 0, 50};
        vt[3]  = '{4'b0010, 50, 1'b0, 4'b0010, 16'h0003, 1'b0, 1'b1, 1'b0, 8'd0, 3, 0, 50};
        vt[4]  = '{4'b0001, 50, 1'b0, 4'b0001, 16'h0004, 1'b0, 1'b1, 1'b0, 8'd0, 4, 0, 50};
        vt[5]  = '{4'b0000, 50, 1'b0, 4'b0000, 16'h0004, 1'b0, 1'b0, 1'b0, 8'd0, 4, 0, 50};
        vt[6]  = '{4'b0001, 50, 1'b1, 4'b0001, 16'h0000, 1'b0, 1'b1, 1'b0, 8'd0, 4, 0, 50};
        vt[7]  = '{4'b0010, 50, 1'b0, 4'b0010, 16'hFFFF, 1'b1, 1'b1, 1'b0, 8'd0, 5, 0, 99};
        vt[8]  = '{4'b0100, 50, 1'b0, 4'b0100, 16'hFFFE, 1'b1, 1'b1, 1'b0, 8'd0, 6, 0, 50};
        vt[9]  = '{4'b0000, 50, 1'b0, 4'b0000, 16'hFFFE, 1'b1, 1'b0, 1'b0, 8'd0, 6, 0, 50};
        vt[10] = '{4'b0001, 50, 1'b0, 4'b0001, 16'hFFFE, 1'b1, 1'b1, 1'b0, 8'd0, 6, 0, -1};
        vt[11] = '{4'b1000, 3,  1'b0, 4'b0001, 16'hFFFE, 1'b1, 1'b1, 1'b0, 8'd0, 6, 0, -1};
        vt[12] = '{4'b0001, 50, 1'b0, 4'b0001, 16'hFFFE, 1'b1, 1'b1, 1'b0, 8'd0, 6, 0, -1};
        vt[13] = '{4'b0100, 50, 1'b0, 4'b0100, 16'hFFFE, 1'b1, 1'b0, 1'b1, 8'd1, 6, 1, -1};
        vt[14] = '{4'b0011, 50, 1'b0, 4'b0011, 16'hFFFE, 1'b1, 1'b0, 1'b1, 8'd2, 6, 2, -1};
        vt[15] = '{4'b1000, 50, 1'b0, 4'b1000, 16'hFFFE, 1'b1, 1'b1, 1'b1, 8'd2, 6, 2, -1};

        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst_init");
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_vals("post_rel");

        b_step = n_step;
        b_err = n_err;
        for (int r = 0; r < 16; r++) begin
            phase_in = vt[r].ph;
            pos_clr = vt[r].pclr;
            repeat (vt[r].hold) begin
                @(posedge clk);
                #1 pos_clr = 1'b0;
            end
            chk($sformatf("r%0d_phase", r), 32'(phase), 32'(vt[r].e_phase));
            chk($sformatf("r%0d_pos", r), 32'(pos), 32'(vt[r].e_pos));
            chk($sformatf("r%0d_dir", r), 32'(dir_out), 32'(vt[r].e_dir));
            chk($sformatf("r%0d_moving", r), 32'(moving), 32'(vt[r].e_mov));
            chk($sformatf("r%0d_fault", r), 32'(fault), 32'(vt[r].e_flt));
            chk($sformatf("r%0d_errcnt", r), 32'(err_cnt), 32'(vt[r].e_ecnt));
            chk($sformatf("r%0d_steps", r), 32'(n_step - b_step), 32'(vt[r].e_steps));
            chk($sformatf("r%0d_errs", r), 32'(n_err - b_err), 32'(vt[r].e_errs));
            if (vt[r].e_per >= 0)
                chk($sformatf("r%0d_period", r), 32'(period), 32'(vt[r].e_per));
        end

        // pos_clr coinciding with a forward step at pos=7
        do_reset();
        hold(4'b0001, 10);
        hold(4'b1000, 10);
        hold(4'b0100, 10);
        hold(4'b0010, 10);
        hold(4'b0001, 10);
        hold(4'b1000, 10);
        hold(4'b0100, 10);
        hold(4'b0010, 10);
        chk("clr_pre_pos", 32'(pos), 32'd7);
        phase_in = 4'b0001;
        repeat (5) @(posedge clk);
        #1 pos_clr = 1'b1;
        @(posedge clk);
        #1 pos_clr = 1'b0;
        chk("clr_latency_step", 32'(step_pulse), 32'd1);
        chk("clr_pos", 32'(pos), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("clr_pos_hold", 32'(pos), 32'd0);
        chk("clr_phase", 32'(phase), 32'h1);

        // error counter saturation and clear
        do_reset();
        b_err = n_err;
        for (int i = 0; i < 300; i++)
            hold((i % 2 == 1) ? 4'b0110 : 4'b0011, 8);
        chk("sat_errs", 32'(n_err - b_err), 32'd300);
        chk("sat_errcnt", 32'(err_cnt), 32'd255);
        chk("sat_fault", 32'(fault), 32'd1);
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        chk("eclr_errcnt", 32'(err_cnt), 32'd0);
        chk("eclr_fault", 32'(fault), 32'd0);

        // reset while RUN with a filter count pending
        do_reset();
        hold(4'b0001, 10);
        chk("mid_moving_pre", 32'(moving), 32'd1);
        phase_in = 4'b1000;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk_reset_vals("mid_rst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        b_err = n_err;
        repeat (12) @(posedge clk);
        #1;
        chk("mid_errcnt", 32'(err_cnt), 32'd1);
        chk("mid_fault", 32'(fault), 32'd1);
        chk("mid_errs", 32'(n_err - b_err), 32'd1);
        chk("mid_moving", 32'(moving), 32'd0);
        chk("mid_pos", 32'(pos), 32'd0);
        chk("mid_phase", 32'(phase), 32'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
